// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - EX/MEM/WB control stage registers with load-use stall and forwarding selects
module ctrl_pipeline #(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4,
  parameter int LINK_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic                  d_reg_write,
  input  logic                  d_mem_to_reg,
  input  logic                  d_mem_write,
  input  logic [ALU_OP_W-1:0]   d_alu_op,
  input  logic                  d_alu_src,
  input  logic                  d_reg_dest,
  input  logic                  d_jump_link,
  input  logic [REG_ADDR_W-1:0] d_rs,
  input  logic [REG_ADDR_W-1:0] d_rt,
  input  logic [REG_ADDR_W-1:0] d_rd,
  input  logic                  flush_e,
  output logic                  stall_fd,
  output logic [ALU_OP_W-1:0]   e_alu_op,
  output logic                  e_alu_src,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  m_mem_write,
  output logic                  m_mem_to_reg,
  output logic                  w_reg_write,
  output logic                  w_mem_to_reg,
  output logic [REG_ADDR_W-1:0] w_write_reg
);

  localparam logic [REG_ADDR_W-1:0] LINK = REG_ADDR_W'(LINK_REG);

  logic                  e_valid, e_wen, e_mem_to_reg, e_mem_write;
  logic [REG_ADDR_W-1:0] e_wreg, e_rs, e_rt;
  logic                  m_wen;
  logic [REG_ADDR_W-1:0] m_wreg;

  logic                  d_wen, bubble;
  logic [REG_ADDR_W-1:0] d_wreg;

  always_comb begin
    d_wreg = d_jump_link ? LINK : (d_reg_dest ? d_rd : d_rt);
    d_wen  = d_valid & (d_reg_write | d_mem_to_reg) & ~d_mem_write;
    stall_fd = e_valid & e_mem_to_reg & (e_wreg != '0) & d_valid &
               ((d_rs == e_wreg) | (d_rt == e_wreg));
    bubble = stall_fd | flush_e | ~d_valid;
  end

  // MEM result takes priority over WB; register 0 is never forwarded.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (m_wen && m_wreg != '0 && m_wreg == e_rs)
      fwd_a_e = 2'b10;
    else if (w_reg_write && w_write_reg != '0 && w_write_reg == e_rs)
      fwd_a_e = 2'b01;
    if (m_wen && m_wreg != '0 && m_wreg == e_rt)
      fwd_b_e = 2'b10;
    else if (w_reg_write && w_write_reg != '0 && w_write_reg == e_rt)
      fwd_b_e = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_valid      <= 1'b0;
      e_wen        <= 1'b0;
      e_mem_to_reg <= 1'b0;
      e_mem_write  <= 1'b0;
      e_alu_op     <= '0;
      e_alu_src    <= 1'b0;
      e_wreg       <= '0;
      e_rs         <= '0;
      e_rt         <= '0;
      m_wen        <= 1'b0;
      m_wreg       <= '0;
      m_mem_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      w_reg_write  <= 1'b0;
      w_mem_to_reg <= 1'b0;
      w_write_reg  <= '0;
    end else begin
      if (bubble) begin
        e_valid      <= 1'b0;
        e_wen        <= 1'b0;
        e_mem_to_reg <= 1'b0;
        e_mem_write  <= 1'b0;
        e_alu_op     <= '0;
        e_alu_src    <= 1'b0;
        e_wreg       <= '0;
        e_rs         <= '0;
        e_rt         <= '0;
      end else begin
        e_valid      <= 1'b1;
        e_wen        <= d_wen;
        e_mem_to_reg <= d_mem_to_reg;
        e_mem_write  <= d_mem_write;
        e_alu_op     <= d_alu_op;
        e_alu_src    <= d_alu_src;
        e_wreg       <= d_wreg;
        e_rs         <= d_rs;
        e_rt         <= d_rt;
      end
      m_wen        <= e_wen;
      m_wreg       <= e_wreg;
      m_mem_write  <= e_mem_write;
      m_mem_to_reg <= e_mem_to_reg;
      w_reg_write  <= m_wen;
      w_mem_to_reg <= m_mem_to_reg;
      w_write_reg  <= m_wreg;
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard bench for ctrl_pipeline with directed control bundles
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_valid, d_reg_write, d_mem_to_reg, d_mem_write;
  logic [3:0] d_alu_op;
  logic       d_alu_src, d_reg_dest, d_jump_link;
  logic [4:0] d_rs, d_rt, d_rd;
  logic       flush_e;
  logic       stall_fd;
  logic [3:0] e_alu_op;
  logic       e_alu_src;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       m_mem_write, m_mem_to_reg;
  logic       w_reg_write, w_mem_to_reg;
  logic [4:0] w_write_reg;

  ctrl_pipeline dut (
    .clk(clk), .reset(reset),
    .d_valid(d_valid), .d_reg_write(d_reg_write), .d_mem_to_reg(d_mem_to_reg),
    .d_mem_write(d_mem_write), .d_alu_op(d_alu_op), .d_alu_src(d_alu_src),
    .d_reg_dest(d_reg_dest), .d_jump_link(d_jump_link),
    .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .flush_e(flush_e),
    .stall_fd(stall_fd), .e_alu_op(e_alu_op), .e_alu_src(e_alu_src),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .m_mem_write(m_mem_write), .m_mem_to_reg(m_mem_to_reg),
    .w_reg_write(w_reg_write), .w_mem_to_reg(w_mem_to_reg), .w_write_reg(w_write_reg)
  );

  always #5 clk = ~clk;

  typedef enum int {
    STALL, E_ALU_OP, E_ALU_SRC, FWD_A, FWD_B, M_MEM_WRITE,
    M_MEM_TO_REG, W_REG_WRITE, W_MEM_TO_REG, W_WRITE_REG
  } sig_e;

  typedef struct {
    int   cyc;
    sig_e sig;
    int   val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(sig_e s);
    case (s)
      STALL:        return int'(stall_fd);
      E_ALU_OP:     return int'(e_alu_op);
      E_ALU_SRC:    return int'(e_alu_src);
      FWD_A:        return int'(fwd_a_e);
      FWD_B:        return int'(fwd_b_e);
      M_MEM_WRITE:  return int'(m_mem_write);
      M_MEM_TO_REG: return int'(m_mem_to_reg);
      W_REG_WRITE:  return int'(w_reg_write);
      W_MEM_TO_REG: return int'(w_mem_to_reg);
      default:      return int'(w_write_reg);
    endcase
  endfunction

  // Monitor: retires every expectation due in the current cycle, away from the clock edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc || actual(sb[i].sig) != sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%0d expected=%0d", sb[i].sig.name(),
                   sb[i].cyc, actual(sb[i].sig), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int dt, input sig_e s, input int v);
    exp_t e;
    e.cyc = cyc + dt;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_zero(input int dt);
    for (int s = 0; s <= int'(W_WRITE_REG); s++) expect_at(dt, sig_e'(s), 0);
  endtask

  task automatic bundle(input int v, input int rw, input int m2r, input int mw, input int op,
                        input int src, input int dst, input int jl, input int rs, input int rt,
                        input int rd, input int fl);
    d_valid      = v[0];
    d_reg_write  = rw[0];
    d_mem_to_reg = m2r[0];
    d_mem_write  = mw[0];
    d_alu_op     = op[3:0];
    d_alu_src    = src[0];
    d_reg_dest   = dst[0];
    d_jump_link  = jl[0];
    d_rs         = rs[4:0];
    d_rt         = rt[4:0];
    d_rd         = rd[4:0];
    flush_e      = fl[0];
  endtask

  task automatic idle();
    bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    expect_zero(0);
    reset = 1'b0;

    // Three bundles in flight, then a mid-stream reset.
    bundle(1, 0, 1, 0, 2, 1, 0, 0, 1, 7, 0, 0);       // LW r7
    step();
    bundle(1, 1, 0, 0, 5, 0, 1, 0, 2, 3, 8, 0);       // ADDU r8
    step();
    bundle(1, 1, 0, 0, 9, 1, 0, 0, 8, 7, 0, 0);       // reads r8 (MEM) and r7 (WB)
    step();
    expect_at(0, FWD_A, 2);
    expect_at(0, FWD_B, 1);
    expect_at(0, W_MEM_TO_REG, 1);
    expect_at(0, W_WRITE_REG, 7);
    expect_at(0, E_ALU_OP, 9);
    reset = 1'b1;
    bundle(1, 1, 1, 0, 3, 1, 0, 0, 4, 6, 0, 0);
    step();
    reset = 1'b0;
    idle();
    expect_zero(0);
    step();

    // ADDU r3
    bundle(1, 1, 0, 0, 1, 0, 1, 0, 1, 2, 3, 0);
    expect_at(1, E_ALU_OP, 1);
    expect_at(1, E_ALU_SRC, 0);
    expect_at(2, M_MEM_WRITE, 0);
    expect_at(3, W_REG_WRITE, 1);
    expect_at(3, W_WRITE_REG, 3);
    expect_at(3, W_MEM_TO_REG, 0);
    step();

    // LW r5 followed by a consumer of r5
    bundle(1, 0, 1, 0, 2, 1, 0, 0, 1, 5, 0, 0);
    expect_at(0, STALL, 0);
    step();
    bundle(1, 1, 0, 0, 3, 0, 1, 0, 5, 6, 9, 0);
    expect_at(0, STALL, 1);
    step();
    expect_at(0, STALL, 0);
    expect_at(0, E_ALU_OP, 0);
    expect_at(0, E_ALU_SRC, 0);
    expect_at(0, M_MEM_TO_REG, 1);
    expect_at(1, E_ALU_OP, 3);
    expect_at(1, FWD_A, 1);
    expect_at(1, FWD_B, 0);
    step();

    // Back-to-back: write r4, read r4; write r0, read r0
    bundle(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 4, 0);
    expect_at(0, STALL, 0);
    step();
    bundle(1, 1, 0, 0, 1, 0, 1, 0, 0, 4, 10, 0);
    expect_at(1, FWD_B, 2);
    expect_at(1, FWD_A, 0);
    step();
    bundle(1, 1, 0, 0, 1, 0, 1, 0, 1, 2, 0, 0);
    step();
    bundle(1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 14, 0);
    expect_at(1, FWD_B, 0);
    expect_at(1, FWD_A, 0);
    step();

    // JAL
    bundle(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 12, 0);
    expect_at(3, W_WRITE_REG, 31);
    expect_at(3, W_REG_WRITE, 1);
    step();

    // SW with reg_write set
    bundle(1, 1, 0, 1, 0, 1, 0, 0, 1, 2, 0, 0);
    expect_at(1, E_ALU_SRC, 1);
    expect_at(2, M_MEM_WRITE, 1);
    expect_at(3, W_REG_WRITE, 0);
    step();

    // Flushed load, then a consumer of its register flows normally
    bundle(1, 1, 1, 0, 7, 1, 0, 0, 1, 6, 0, 1);
    expect_at(1, E_ALU_OP, 0);
    expect_at(1, E_ALU_SRC, 0);
    expect_at(2, M_MEM_TO_REG, 0);
    expect_at(2, M_MEM_WRITE, 0);
    expect_at(3, W_REG_WRITE, 0);
    expect_at(3, W_MEM_TO_REG, 0);
    expect_at(3, W_WRITE_REG, 0);
    step();
    bundle(1, 1, 0, 0, 6, 0, 1, 0, 6, 0, 11, 0);
    expect_at(0, STALL, 0);
    expect_at(1, E_ALU_OP, 6);
    expect_at(3, W_REG_WRITE, 1);
    expect_at(3, W_WRITE_REG, 11);
    step();

    // Invalid slot carrying control bits becomes a bubble
    bundle(0, 1, 0, 0, 8, 1, 1, 0, 0, 0, 13, 0);
    expect_at(1, E_ALU_OP, 0);
    expect_at(3, W_REG_WRITE, 0);
    step();
    idle();

    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < sb.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL unretired %s cyc=%0d expected=%0d", sb[i].sig.name(), sb[i].cyc, sb[i].val);
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL watchdog timeout cyc=%0d", cyc);
      $fatal(1);
    end
  end

endmodule
